// File: rtl/display_scan_controller.sv
// Four-digit common-anode scan driver: double-buffered value, per-digit decode
// (hex / BCD with leading-zero blanking / voltage with dp), registered outputs.
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] display_value,
  input  logic        value_valid,
  input  logic [1:0]  mode,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pend_val, act_val;
  logic [1:0]    pend_mode, act_mode;
  logic          digit_wrap, frame_wrap;

  assign digit_wrap = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_wrap = digit_wrap && (idx == 2'd3);

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // lz[k]: every nibble from digit 3 down to digit k is zero
  logic [3:0] lz;
  logic [3:0] nib;
  logic [6:0] seg_nx;
  logic       dp_nx;

  always_comb begin
    lz[3] = (act_val[15:12] == 4'h0);
    lz[2] = lz[3] && (act_val[11:8] == 4'h0);
    lz[1] = lz[2] && (act_val[7:4] == 4'h0);
    lz[0] = 1'b0;
    nib    = act_val[{idx, 2'b00} +: 4];
    seg_nx = hex_glyph(nib);
    dp_nx  = 1'b1;
    case (act_mode)
      2'b00: ;
      2'b01: begin
        if (lz[idx])        seg_nx = SEG_BLANK;
        else if (nib > 4'd9) seg_nx = SEG_DASH;
      end
      default: begin
        if (nib > 4'd9) seg_nx = SEG_DASH;
        dp_nx = (idx != 2'd3);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pend_val   <= '0;
      pend_mode  <= 2'b00;
      act_val    <= '0;
      act_mode   <= 2'b00;
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt <= digit_wrap ? '0 : cnt + 1'b1;
      if (digit_wrap) idx <= idx + 2'd1;
      if (value_valid) begin
        pend_val  <= display_value;
        pend_mode <= mode;
      end
      // a strobe landing on the frame boundary goes straight to active
      if (frame_wrap) begin
        act_val  <= value_valid ? display_value : pend_val;
        act_mode <= value_valid ? mode : pend_mode;
      end
      frame_done <= frame_wrap;
      an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      seg <= seg_nx;
      dp  <= dp_nx;
    end
  end
endmodule
